// File: rtl/bolme_pkg.sv
// bolme_pkg: shared types and constants for the sequential restoring divider.
// Holds the controller state enum, the default operand width and the
// step-counter width derived from it.
package bolme_pkg;

  // Default operand width; the dividend is twice this wide.
  localparam int BOLME_VERI_W  = 32;

  // Step counter must be able to hold 0..BOLME_VERI_W.
  localparam int BOLME_SAYAC_W = $clog2(BOLME_VERI_W + 1);

  // Controller states: idle, iterating, result strobe.
  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    HESAP = 2'd1,
    BITTI = 2'd2
  } bolme_durum_t;

endpackage

// File: rtl/bolme_adim.sv
// bolme_adim: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference only when it does not borrow.
module bolme_adim
  import bolme_pkg::*;
#(
  parameter int VERI_W = BOLME_VERI_W
) (
  input  logic [VERI_W:0]   i_kalan,
  input  logic              i_bit,
  input  logic [VERI_W-1:0] i_bolen,
  output logic [VERI_W:0]   o_kalan,
  output logic              o_bit
);

  logic [VERI_W+1:0] w_kaydir;
  logic [VERI_W:0]   w_fark;

  // Shift, trial-subtract, restore on borrow.
  always_comb begin
    w_kaydir = {i_kalan, i_bit};
    // The remainder entering a step is always below the divisor, so when
    // the trial subtraction succeeds the true difference fits in VERI_W+1 bits.
    w_fark   = w_kaydir[VERI_W:0] - {1'b0, i_bolen};
    o_bit    = (w_kaydir >= {2'b00, i_bolen});
    o_kalan  = o_bit ? w_fark : w_kaydir[VERI_W:0];
  end

endmodule

// File: rtl/bolme.sv
// bolme: sequential restoring divider, 2*VERI_W-bit dividend by VERI_W-bit
// divisor, one quotient bit per clock, start/ready/valid handshake.
// Divide-by-zero and quotient overflow are reported on tasma with zeroed
// results. Defining BOLME_ISARETLI_EN adds the isaretli input for
// two's-complement operation (sign fixup on the final step).
module bolme
  import bolme_pkg::*;
#(
  parameter int VERI_W = BOLME_VERI_W
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef BOLME_ISARETLI_EN
  input  logic                  isaretli,
`endif
  input  logic                  basla,
  input  logic [2*VERI_W-1:0]   sayi1,
  input  logic [VERI_W-1:0]     sayi2,
  output logic                  hazir,
  output logic                  gecerli,
  output logic                  tasma,
  output logic [VERI_W-1:0]     bolum,
  output logic [VERI_W-1:0]     kalan
);

  localparam int SAYAC_W = $clog2(VERI_W + 1);

  bolme_durum_t         r_durum;
  logic [SAYAC_W-1:0]   r_sayac;
  logic [VERI_W:0]      r_kalan_kismi;  // partial remainder
  logic [VERI_W-1:0]    r_alt;          // low dividend bits out, quotient bits in
  logic [VERI_W-1:0]    r_bolen;
  logic                 r_tasma;
  logic [VERI_W-1:0]    r_bolum;
  logic [VERI_W-1:0]    r_kalan;
`ifdef BOLME_ISARETLI_EN
  logic                 r_isaretli;
  logic                 r_bolunen_isaret;
  logic                 r_bolen_isaret;
  logic                 w_negatif;
  logic [VERI_W-1:0]    w_sinir;
`endif

  logic [2*VERI_W-1:0]  w_bolunen_mut;
  logic [VERI_W-1:0]    w_bolen_mut;
  logic                 w_giris_hata;
  logic [VERI_W:0]      w_kalan_yeni;
  logic                 w_q;
  logic [VERI_W-1:0]    w_bolum_ham;
  logic                 w_son_adim;
  logic                 w_sonuc_tasma;
  logic [VERI_W-1:0]    w_bolum_son;
  logic [VERI_W-1:0]    w_kalan_son;

  bolme_adim #(.VERI_W(VERI_W)) u_adim (
    .i_kalan (r_kalan_kismi),
    .i_bit   (r_alt[VERI_W-1]),
    .i_bolen (r_bolen),
    .o_kalan (w_kalan_yeni),
    .o_bit   (w_q)
  );

  // Operand magnitudes and the accept-time error check.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing branch would otherwise infer a latch.
    w_bolunen_mut = sayi1;
    w_bolen_mut   = sayi2;
`ifdef BOLME_ISARETLI_EN
    if (isaretli && sayi1[2*VERI_W-1]) w_bolunen_mut = -sayi1;
    if (isaretli && sayi2[VERI_W-1])   w_bolen_mut   = -sayi2;
`endif
    // Upper half >= divisor means the quotient cannot fit in VERI_W bits.
    w_giris_hata = (sayi2 == '0) || (w_bolunen_mut[2*VERI_W-1:VERI_W] >= w_bolen_mut);
  end

  // Final-step result assembly, with sign fixup when enabled.
  always_comb begin
    w_bolum_ham   = {r_alt[VERI_W-2:0], w_q};
    w_son_adim    = (r_sayac == SAYAC_W'(VERI_W - 1));
    w_sonuc_tasma = 1'b0;
    w_bolum_son   = w_bolum_ham;
    w_kalan_son   = w_kalan_yeni[VERI_W-1:0];
`ifdef BOLME_ISARETLI_EN
    w_negatif     = r_isaretli & (r_bolunen_isaret ^ r_bolen_isaret);
    // Largest representable magnitude: 2^(W-1)-1 positive, 2^(W-1) negative.
    w_sinir       = {1'b0, {(VERI_W-1){1'b1}}} + VERI_W'(w_negatif);
    w_sonuc_tasma = r_isaretli && (w_bolum_ham > w_sinir);
    if (w_negatif)        w_bolum_son = -w_bolum_ham;
    if (r_bolunen_isaret) w_kalan_son = -w_kalan_yeni[VERI_W-1:0];
`endif
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_durum          <= BOSTA;
      r_sayac          <= '0;
      r_kalan_kismi    <= '0;
      r_alt            <= '0;
      r_bolen          <= '0;
      r_tasma          <= 1'b0;
      r_bolum          <= '0;
      r_kalan          <= '0;
`ifdef BOLME_ISARETLI_EN
      r_isaretli       <= 1'b0;
      r_bolunen_isaret <= 1'b0;
      r_bolen_isaret   <= 1'b0;
`endif
    end else begin
      case (r_durum)
        BOSTA: begin
          if (basla) begin
            r_bolen       <= w_bolen_mut;
            r_kalan_kismi <= {1'b0, w_bolunen_mut[2*VERI_W-1:VERI_W]};
            r_alt         <= w_bolunen_mut[VERI_W-1:0];
            r_sayac       <= '0;
`ifdef BOLME_ISARETLI_EN
            r_isaretli       <= isaretli;
            r_bolunen_isaret <= isaretli & sayi1[2*VERI_W-1];
            r_bolen_isaret   <= isaretli & sayi2[VERI_W-1];
`endif
            if (w_giris_hata) begin
              r_tasma <= 1'b1;
              r_bolum <= '0;
              r_kalan <= '0;
              r_durum <= BITTI;
            end else begin
              r_durum <= HESAP;
            end
          end
        end
        HESAP: begin
          r_kalan_kismi <= w_kalan_yeni;
          r_alt         <= w_bolum_ham;
          r_sayac       <= r_sayac + SAYAC_W'(1);
          if (w_son_adim) begin
            r_durum <= BITTI;
            if (w_sonuc_tasma) begin
              r_tasma <= 1'b1;
              r_bolum <= '0;
              r_kalan <= '0;
            end else begin
              r_tasma <= 1'b0;
              r_bolum <= w_bolum_son;
              r_kalan <= w_kalan_son;
            end
          end
        end
        BITTI:   r_durum <= BOSTA;
        default: r_durum <= BOSTA;
      endcase
    end
  end

  assign hazir   = (r_durum == BOSTA);
  assign gecerli = (r_durum == BITTI);
  assign tasma   = r_tasma;
  assign bolum   = r_bolum;
  assign kalan   = r_kalan;

endmodule
